// File: rtl/proc_write_arbiter_pkg.sv
// Shared widths, transaction-type codes and FSM encoding for the process write arbiter.
package proc_write_arbiter_pkg;

    localparam int PID_WIDTH     = 4;
    localparam int PAWUSER_WIDTH = 2;

    localparam logic [PAWUSER_WIDTH-1:0] REGULAR = 2'd0;
    localparam logic [PAWUSER_WIDTH-1:0] DIVERT  = 2'd1;
    localparam logic [PAWUSER_WIDTH-1:0] BLOCK   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // DIVERT and BLOCK writes jump the queue when priority arbitration is built in.
    function automatic logic is_priority(input logic [PAWUSER_WIDTH-1:0] ttype);
        return ttype != REGULAR;
    endfunction

endpackage

// File: rtl/proc_write_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping cyclically.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] idx
);

    logic found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // NUM_REQ is a power of two, so the index addition wraps on its own.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_WIDTH'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant[idx] = found;
    end

endmodule

// File: rtl/proc_write_arbiter.sv
// Round-robin AW/W arbiter sharing one downstream AXI write port; B demuxed by ID prefix.
// Optional build macro PROC_ARB_SPEC_PRIORITY_EN favours DIVERT/BLOCK requesters.
module proc_write_arbiter
    import proc_write_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_WIDTH  = $clog2(NUM_MASTERS),
    parameter int LID_WIDTH   = PID_WIDTH - MIDX_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_awvalid,
    input  logic [NUM_MASTERS*LID_WIDTH-1:0]       m_awid,
    input  logic [NUM_MASTERS*PAWUSER_WIDTH-1:0]   m_awuser,
    output logic [NUM_MASTERS-1:0]                 m_awready,
    input  logic [NUM_MASTERS-1:0]                 m_wvalid,
    input  logic [NUM_MASTERS-1:0]                 m_wlast,
    output logic [NUM_MASTERS-1:0]                 m_wready,
    output logic [NUM_MASTERS-1:0]                 m_bvalid,
    input  logic [NUM_MASTERS-1:0]                 m_bready,
    output logic                                   awvalid,
    output logic [PID_WIDTH-1:0]                   awid,
    output logic [PAWUSER_WIDTH-1:0]               awuser,
    input  logic                                   awready,
    output logic                                   wvalid,
    output logic [PID_WIDTH-1:0]                   wid,
    output logic                                   wlast,
    input  logic                                   wready,
    input  logic                                   bvalid,
    input  logic [PID_WIDTH-1:0]                   bid,
    output logic                                   bready,
    input  logic                                   mem_full,
    input  logic                                   to_block,
    output logic [MIDX_WIDTH-1:0]                  grant_idx,
    output logic                                   busy
);

    arb_state_t              state;
    logic [MIDX_WIDTH-1:0]   rr_ptr;
    logic [LID_WIDTH-1:0]    lid_q;

    logic [LID_WIDTH-1:0]     lid_arr  [NUM_MASTERS];
    logic [PAWUSER_WIDTH-1:0] user_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign lid_arr[i]  = m_awid[i*LID_WIDTH +: LID_WIDTH];
        assign user_arr[i] = m_awuser[i*PAWUSER_WIDTH +: PAWUSER_WIDTH];
    end

    logic [NUM_MASTERS-1:0] rr_grant;
    logic [MIDX_WIDTH-1:0]  rr_idx;
    logic [NUM_MASTERS-1:0] win_grant;
    logic [MIDX_WIDTH-1:0]  win_idx;
    logic [LID_WIDTH-1:0]   win_lid;
    logic                   arb_go;
    logic                   aw_done;
    logic                   w_done;

    rr_arbiter #(
        .NUM_REQ   (NUM_MASTERS),
        .IDX_WIDTH (MIDX_WIDTH)
    ) u_rr (
        .req   (m_awvalid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

`ifdef PROC_ARB_SPEC_PRIORITY_EN
    logic [NUM_MASTERS-1:0] prio_req;
    logic [NUM_MASTERS-1:0] prio_grant;
    logic [MIDX_WIDTH-1:0]  prio_idx;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_prio
        assign prio_req[i] = m_awvalid[i] && is_priority(user_arr[i]);
    end

    // Same pointer for both passes; regular masters only win when no special write waits.
    rr_arbiter #(
        .NUM_REQ   (NUM_MASTERS),
        .IDX_WIDTH (MIDX_WIDTH)
    ) u_prio (
        .req   (prio_req),
        .ptr   (rr_ptr),
        .grant (prio_grant),
        .idx   (prio_idx)
    );

    assign win_grant = (|prio_req) ? prio_grant : rr_grant;
    assign win_idx   = (|prio_req) ? prio_idx   : rr_idx;
`else
    assign win_grant = rr_grant;
    assign win_idx   = rr_idx;
`endif

    always_comb begin
        win_lid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_grant[i]) win_lid = lid_arr[i];
        end
    end

    assign arb_go  = (state == IDLE) && (|m_awvalid) && !mem_full && !to_block;
    assign aw_done = (state == ADDR) && awready;
    assign w_done  = wvalid && wready && wlast;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            lid_q     <= '0;
        end else begin
            case (state)
                IDLE: if (arb_go) begin
                    grant_idx <= win_idx;
                    lid_q     <= win_lid;
                    state     <= ADDR;
                end
                ADDR: if (aw_done) begin
                    rr_ptr <= grant_idx + 1'b1;
                    state  <= DATA;
                end
                DATA: if (w_done) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign awvalid = (state == ADDR);
    assign awid    = {grant_idx, lid_q};
    assign awuser  = user_arr[grant_idx];
    assign wid     = {grant_idx, lid_q};
    assign wvalid  = (state == DATA) && m_wvalid[grant_idx];
    assign wlast   = (state == DATA) && m_wlast[grant_idx];
    assign busy    = (state != IDLE);

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        if (state == ADDR) m_awready[grant_idx] = awready;
        if (state == DATA) m_wready[grant_idx]  = wready;
    end

    // Write responses bypass the FSM entirely and route on the master-index prefix.
    logic [MIDX_WIDTH-1:0] b_idx;
    logic                  unused_bid_lo;

    assign b_idx         = bid[PID_WIDTH-1 -: MIDX_WIDTH];
    assign bready        = m_bready[b_idx];
    assign unused_bid_lo = ^bid[LID_WIDTH-1:0];

    always_comb begin
        m_bvalid        = '0;
        m_bvalid[b_idx] = bvalid;
    end

endmodule

// File: tb/tb_proc_write_arbiter.sv
// Self-checking bench for proc_write_arbiter: directed steps plus randomized bursts vs a reference model.
module tb_proc_write_arbiter;
    import proc_write_arbiter_pkg::*;

    localparam int NM = 4;
    localparam int MW = 2;
    localparam int LW = PID_WIDTH - MW;
`ifdef PROC_ARB_SPEC_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NM-1:0]                 m_awvalid;
    logic [NM*LW-1:0]              m_awid;
    logic [NM*PAWUSER_WIDTH-1:0]   m_awuser;
    logic [NM-1:0]                 m_awready;
    logic [NM-1:0]                 m_wvalid;
    logic [NM-1:0]                 m_wlast;
    logic [NM-1:0]                 m_wready;
    logic [NM-1:0]                 m_bvalid;
    logic [NM-1:0]                 m_bready;
    logic                          awvalid;
    logic [PID_WIDTH-1:0]          awid;
    logic [PAWUSER_WIDTH-1:0]      awuser;
    logic                          awready;
    logic                          wvalid;
    logic [PID_WIDTH-1:0]          wid;
    logic                          wlast;
    logic                          wready;
    logic                          bvalid;
    logic [PID_WIDTH-1:0]          bid;
    logic                          bready;
    logic                          mem_full;
    logic                          to_block;
    logic [MW-1:0]                 grant_idx;
    logic                          busy;

    always #5 clk = ~clk;

    proc_write_arbiter #(.NUM_MASTERS(NM)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awvalid (m_awvalid),
        .m_awid    (m_awid),
        .m_awuser  (m_awuser),
        .m_awready (m_awready),
        .m_wvalid  (m_wvalid),
        .m_wlast   (m_wlast),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .awvalid   (awvalid),
        .awid      (awid),
        .awuser    (awuser),
        .awready   (awready),
        .wvalid    (wvalid),
        .wid       (wid),
        .wlast     (wlast),
        .wready    (wready),
        .bvalid    (bvalid),
        .bid       (bid),
        .bready    (bready),
        .mem_full  (mem_full),
        .to_block  (to_block),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int exp_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requester cyclically from ptr, restricted to non-REGULAR ones when priority is on.
    function automatic int model_pick(input logic [NM-1:0] req,
                                      input logic [NM*PAWUSER_WIDTH-1:0] user,
                                      input int ptr);
        logic [NM-1:0] pri;
        logic [NM-1:0] pool;
        pri = '0;
        for (int i = 0; i < NM; i++)
            pri[i] = req[i] && (user[i*PAWUSER_WIDTH +: PAWUSER_WIDTH] != REGULAR);
        pool = (PRIO_EN && pri != '0) ? pri : req;
        for (int k = 0; k < NM; k++) begin
            if (pool[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_awvalid = '0; m_awid = '0; m_awuser = '0;
        m_wvalid  = '0; m_wlast = '0; m_bready = '0;
        awready   = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0;
        mem_full  = 1'b0; to_block = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic wait_aw(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!awvalid && cycles < 20);
        check("aw_arrives", awvalid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g, cyc, beat, guard, len;
        bit stalled, aw_done;
        logic [NM-1:0] mask;
        logic [LW-1:0] lid;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_m_awready", m_awready, 0);
        check("rst_m_wready", m_wready, 0);

        // All masters requesting, single-beat bursts: grants 0,1,2,3,0
        m_awid = 8'($urandom);
        m_awvalid = 4'hF; m_wvalid = 4'hF; m_wlast = 4'hF;
        awready = 1'b1; wready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            g = model_pick(m_awvalid, m_awuser, exp_ptr);
            check("rr_model_order", g, n % NM);
            lid = m_awid[g*LW +: LW];
            wait_aw(cyc);
            if (n > 0) check("rr_gap", cyc, 2);
            check("rr_grant", grant_idx, g);
            check("rr_awid", awid, {g[1:0], lid});
            check("rr_m_awready", m_awready, 1 << g);
            tick();
            exp_ptr = (g + 1) % NM;
            if (n == 4) m_awvalid = '0;
            @(negedge clk);
            check("rr_m_wready", m_wready, 1 << g);
            check("rr_wid", wid, {g[1:0], lid});
            tick();
        end

        // Master 2, local ID 01, 4-beat burst with a stall on the second beat
        do_reset();
        m_awid = 8'($urandom);
        m_awid[5:4] = 2'b01;
        m_awvalid = 4'b0100; m_wvalid = 4'hF; awready = 1'b1;
        wait_aw(cyc);
        check("burst_awid", awid, 4'b1001);
        tick();
        m_awvalid = '0; awready = 1'b0;
        beat = 0; guard = 0; stalled = 1'b0;
        while (beat < 4 && guard < 20) begin
            guard++;
            m_wlast = (beat == 3) ? 4'hF : 4'h0;
            wready  = !(beat == 1 && !stalled);
            if (beat == 1) stalled = 1'b1;
            @(negedge clk);
            check("burst_wvalid", wvalid, 1);
            check("burst_wid", wid, 4'b1001);
            check("burst_wlast", wlast, beat == 3);
            check("burst_m_wready", m_wready, wready ? 4'b0100 : 4'b0000);
            if (wready) beat++;
            tick();
        end
        check("burst_beats", beat, 4);
        m_wvalid = '0; m_wlast = '0; wready = 1'b0;
        @(negedge clk);
        check("burst_idle", busy, 0);

        // mem_full stalls arbitration, then to_block rises during ADDR
        do_reset();
        m_awid = 8'($urandom);
        mem_full = 1'b1; m_awvalid = 4'b1010;
        repeat (4) begin
            @(negedge clk);
            check("full_awvalid", awvalid, 0);
            check("full_busy", busy, 0);
        end
        tick();
        mem_full = 1'b0;
        g = model_pick(m_awvalid, m_awuser, exp_ptr);
        wait_aw(cyc);
        check("full_release_latency", cyc, 2);
        check("full_grant", grant_idx, g);
        check("full_grant_is_1", grant_idx, 1);
        to_block = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("blk_aw_held", awvalid, 1);
            check("blk_awid", awid, {2'b01, m_awid[3:2]});
        end
        tick();
        awready = 1'b1;
        @(negedge clk);
        check("blk_m_awready", m_awready, 4'b0010);
        tick();
        exp_ptr = 2;
        awready = 1'b0; m_awvalid = 4'b1000;
        m_wvalid = 4'b0010; m_wlast = 4'b0010; wready = 1'b1;
        @(negedge clk);
        check("blk_wvalid", wvalid, 1);
        tick();
        m_wvalid = '0; m_wlast = '0; wready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("blk_no_grant", awvalid, 0);
            check("blk_busy", busy, 0);
        end
        tick();
        to_block = 1'b0;
        g = model_pick(m_awvalid, m_awuser, exp_ptr);
        wait_aw(cyc);
        check("blk_release_grant", grant_idx, g);
        awready = 1'b1;
        tick();
        m_awvalid = '0; awready = 1'b0;
        m_wvalid = 4'b1000; m_wlast = 4'b1000; wready = 1'b1;
        tick();
        m_wvalid = '0; m_wlast = '0; wready = 1'b0;

        // B response routed during master 0's DATA phase
        do_reset();
        m_awvalid = 4'b0001; awready = 1'b1;
        wait_aw(cyc);
        tick();
        m_awvalid = '0; awready = 1'b0;
        m_wvalid = 4'b0001; m_wlast = 4'b0001; wready = 1'b0;
        bvalid = 1'b1; bid = 4'b1110; m_bready = 4'b1000;
        @(negedge clk);
        check("b_m_bvalid", m_bvalid, 4'b1000);
        check("b_bready_hi", bready, 1);
        check("b_w_wvalid", wvalid, 1);
        check("b_w_m_wready_lo", m_wready, 0);
        tick();
        m_bready = 4'b0111; wready = 1'b1;
        @(negedge clk);
        check("b_m_bvalid_2", m_bvalid, 4'b1000);
        check("b_bready_lo", bready, 0);
        check("b_w_m_wready", m_wready, 4'b0001);
        tick();
        bvalid = 1'b0; m_wvalid = '0; m_wlast = '0; wready = 1'b0;
        @(negedge clk);
        check("b_w_done", busy, 0);
        check("b_m_bvalid_off", m_bvalid, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            bvalid   = 1'($urandom);
            bid      = 4'($urandom);
            m_bready = 4'($urandom);
            @(negedge clk);
            check("b_rand_m_bvalid", m_bvalid, bvalid ? (1 << bid[3:2]) : 0);
            check("b_rand_bready", bready, m_bready[bid[3:2]]);
        end
        bvalid = 1'b0;

        // Priority set: master 0 REGULAR vs master 3 DIVERT with rr_ptr at 0
        do_reset();
        m_awuser[1:0] = REGULAR;
        m_awuser[7:6] = DIVERT;
        m_awvalid = 4'b1001;
        wait_aw(cyc);
        check("prio_grant", grant_idx, PRIO_EN ? 3 : 0);
        check("prio_model", grant_idx, model_pick(4'b1001, m_awuser, 0));

        // Randomized bursts against the reference model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            mask   = 4'($urandom_range(1, 15));
            m_awid = 8'($urandom);
            for (int i = 0; i < NM; i++)
                m_awuser[i*PAWUSER_WIDTH +: PAWUSER_WIDTH] = PAWUSER_WIDTH'($urandom_range(0, 2));
            m_awvalid = mask;
            if ($urandom_range(0, 3) == 0) begin
                mem_full = 1'($urandom);
                to_block = !mem_full;
                repeat (2) begin
                    @(negedge clk);
                    check("rnd_stall_awvalid", awvalid, 0);
                    check("rnd_stall_busy", busy, 0);
                end
                tick();
                mem_full = 1'b0; to_block = 1'b0;
            end
            g   = model_pick(mask, m_awuser, exp_ptr);
            lid = m_awid[g*LW +: LW];
            wait_aw(cyc);
            check("rnd_grant", grant_idx, g);
            check("rnd_awid", awid, {g[1:0], lid});
            check("rnd_awuser", awuser, m_awuser[g*PAWUSER_WIDTH +: PAWUSER_WIDTH]);
            aw_done = 1'b0; guard = 0;
            while (!aw_done && guard < 20) begin
                tick();
                awready = 1'($urandom);
                @(negedge clk);
                check("rnd_aw_held", awvalid, 1);
                check("rnd_m_awready", m_awready, awready ? (1 << g) : 0);
                if (awready) aw_done = 1'b1;
                guard++;
            end
            tick();
            awready = 1'b0; m_awvalid = '0;
            exp_ptr = (g + 1) % NM;
            len = $urandom_range(1, 4); beat = 0; guard = 0;
            while (beat < len && guard < 40) begin
                m_wvalid = 4'($urandom);
                if ($urandom_range(0, 3) != 0) m_wvalid[g] = 1'b1;
                m_wlast    = 4'($urandom);
                m_wlast[g] = (beat == len - 1);
                wready     = 1'($urandom);
                @(negedge clk);
                check("rnd_wvalid", wvalid, m_wvalid[g]);
                check("rnd_wlast", wlast, m_wlast[g]);
                check("rnd_m_wready", m_wready, wready ? (1 << g) : 0);
                check("rnd_wid", wid, {g[1:0], lid});
                if (m_wvalid[g] && wready) beat++;
                tick();
                guard++;
            end
            check("rnd_beats", beat, len);
            m_wvalid = '0; m_wlast = '0; wready = 1'b0;
        end
        @(negedge clk);
        check("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proc_write_arbiter.md
Name: proc_write_arbiter

Overview:
- Round-robin arbiter that shares the single downstream AXI write port (AW, W and B channels) among NUM_MASTERS upstream write masters.
- Sits in front of process_mem and the router.
- Sequences each write as address-then-data. The granted master keeps ownership until its W burst completes with wlast.
- Stalls new grants while the process memory is full or the router is blocking.
- Demultiplexes B responses back to the originating master by the ID prefix.

Parameters:
- NUM_MASTERS, 4, number of upstream masters (power of 2, at least 2).
- MIDX_WIDTH, $clog2(NUM_MASTERS), width of the master-index ID prefix.
- LID_WIDTH, PID_WIDTH-MIDX_WIDTH, width of each master's local ID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m_awvalid  in  NUM_MASTERS  per-master AW valid.
- m_awid  in  NUM_MASTERS*LID_WIDTH  per-master local AW ID.
- m_awuser  in  NUM_MASTERS*PAWUSER_WIDTH  per-master transaction type.
- m_awready  out  NUM_MASTERS  per-master AW ready.
- m_wvalid  in  NUM_MASTERS  per-master W valid.
- m_wlast  in  NUM_MASTERS  per-master W last.
- m_wready  out  NUM_MASTERS  per-master W ready.
- m_bvalid  out  NUM_MASTERS  per-master B valid.
- m_bready  in  NUM_MASTERS  per-master B ready.
- awvalid  out  1  downstream AW valid.
- awid  out  PID_WIDTH  downstream ID: {grant_idx, local id}.
- awuser  out  PAWUSER_WIDTH  downstream transaction type.
- awready  in  1  downstream AW ready.
- wvalid  out  1  downstream W valid.
- wid  out  PID_WIDTH  downstream W ID (same value as the AW ID).
- wlast  out  1  downstream W last.
- wready  in  1  downstream W ready.
- bvalid  in  1  downstream B valid.
- bid  in  PID_WIDTH  downstream B ID.
- bready  out  1  downstream B ready.
- mem_full  in  1  full flag from process memory.
- to_block  in  1  router block request.
- grant_idx  out  MIDX_WIDTH  current or last granted master.
- busy  out  1  arbiter state is not IDLE.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, rr_ptr=0, grant_idx=0, all valid/ready outputs 0, busy=0. A reset mid-burst abandons the burst; nothing is replayed.
- State machine states: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate only when at least one m_awvalid is high, mem_full=0 and to_block=0.
  - Winner is the first requester at or after rr_ptr, taken cyclically.
  - Register grant_idx and the winner's local ID, then go to ADDR.
  - The decision takes 1 cycle; awvalid is asserted from the next cycle.
- ADDR:
  - awvalid=1, awid/awuser driven from the granted master, m_awready[g]=awready, all other m_awready=0.
  - On the AW handshake go to DATA and set rr_ptr=grant_idx+1 (mod NUM_MASTERS).
  - AW must not be withdrawn; mem_full or to_block rising while in ADDR does not retract awvalid.
- DATA:
  - wvalid=m_wvalid[g], wlast=m_wlast[g], wid=registered ID, m_wready[g]=wready, all other m_wready=0.
  - On a handshake with wlast=1, return to IDLE. A new arbitration can happen in that same IDLE cycle, giving back-to-back bursts 1 idle cycle apart.
- B path is purely combinational and independent of the state machine:
  - m_bvalid[bid[PID_WIDTH-1 -: MIDX_WIDTH]] = bvalid; all other m_bvalid=0.
  - bready = m_bready[that index].
  - B traffic is allowed in any state, including simultaneously with AW or W handshakes.
- Only one write is in flight on the W channel at a time. Ordering is strict AW-then-W per grant.
- With all masters requesting continuously, grant order is 0,1,2,3,0,...

Optional Feature:
- Macro: PROC_ARB_SPEC_PRIORITY_EN.
- Defined: in IDLE, masters whose m_awuser is not REGULAR (DIVERT or BLOCK) form a priority set, and round-robin runs within that set first. Regular requesters are considered only when the set is empty. rr_ptr updates as normal.
- Undefined: pure round-robin with awuser ignored for arbitration.

Decomposition:
- pkg supplies PID_WIDTH, PAWUSER_WIDTH and the transaction-type constants REGULAR, DIVERT and BLOCK.
- Add to pkg: enum arb_state_t {IDLE, ADDR, DATA}.
- One sub-module: rr_arbiter, a combinational rotate-by-pointer priority selector. Inputs are req and ptr; output is a one-hot grant plus an index. It is reused for the priority-set pass.

Test Plan:
- All 4 masters hold awvalid with 1-beat bursts, awready=wready=1 -> grants 0,1,2,3,0; awid[3:2] equals the master index each time.
- Master 2 requests, m_awid=2'b01, 4-beat burst, wready low on beat 2 -> awid=4'b1001; W stays with master 2 until the wlast handshake; m_wready[other]=0 throughout.
- mem_full=1 while masters 1 and 3 request -> awvalid stays 0 and busy=0; deassert mem_full -> master 1 granted on the next cycle.
- to_block rises during ADDR -> awvalid held until awready; no further grant while to_block=1.
- bvalid=1 with bid=4'b1110 during master 0's DATA phase -> m_bvalid=4'b1000, bready=m_bready[3]; W transfer is unaffected.
- PROC_ARB_SPEC_PRIORITY_EN defined, rr_ptr=0, master 0 REGULAR and master 3 DIVERT both requesting -> master 3 granted first. Macro undefined -> master 0 granted first.
